fu_result_buffer: RTL and testbench
===================================

FU_RESULT_BUFFER -- requirements
Module: fu_result_buffer

Interface
REQ-001 SHALL have parameter NUM_FU, default 8: number of FU result lanes; lane 7 is the branch unit and lane 0 is alu_1.
REQ-002 SHALL have parameter DEPTH, default 2: entries per lane FIFO; legal values 2 and 4.
REQ-003 SHALL have parameter XLEN, default 32: data and PC width.
REQ-004 SHALL have parameters PR_W, default 6, and ROB_W, default 5: physical-register and ROB-index widths.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 squash  in  1  flushes all lanes (mispredict recovery).
REQ-009 fu_valid  in  NUM_FU  per-lane FU result present.
REQ-010 fu_value  in  NUM_FU*XLEN  result data.
REQ-011 fu_prs  in  NUM_FU*PR_W  destination physical register.
REQ-012 fu_rob  in  NUM_FU*ROB_W  ROB entry.
REQ-013 fu_br_taken  in  NUM_FU  branch-taken flag.
REQ-014 fu_br_pc  in  NUM_FU*XLEN  branch target PC.
REQ-015 fu_ready  out  NUM_FU  lane can accept a result this cycle.
REQ-016 cs_stall_mask  in  NUM_FU  from the complete stage: 1 means the lane head was not selected this cycle.
REQ-017 buf_done_flags  out  NUM_FU  lane head valid; feeds the complete stage's done flags.
REQ-018 buf_value, buf_prs, buf_rob, buf_br_taken, buf_br_pc  out  per-lane head fields, same widths as the corresponding inputs.
REQ-019 buf_count  out  NUM_FU*($clog2(DEPTH)+1)  per-lane occupancy.

Function
REQ-020 SHALL keep one independent FIFO per lane, each with head pointer, tail pointer and count.
REQ-021 SHALL define push[i] = fu_valid[i] & fu_ready[i] & ~squash.
REQ-022 SHALL define pop[i] = buf_done_flags[i] & ~cs_stall_mask[i] & ~squash.
REQ-023 SHALL drive fu_ready[i] = (count[i] < DEPTH), a function of registered count only; there SHALL be no combinational path from cs_stall_mask to fu_ready.
REQ-024 SHALL give a 1-cycle latency: a result pushed at edge N is visible at the head after edge N; there is no same-cycle bypass.
REQ-025 SHALL drive buf_done_flags[i] = (count[i] != 0) and the head fields from the entry at the head pointer; head fields are don't-care when empty.
REQ-026 Simultaneous push and pop on a lane: count unchanged, both pointers advance, FIFO order preserved.
REQ-027 Push while full is impossible, because fu_ready=0; fu_valid while full SHALL be ignored, with no state change.
REQ-028 Pop while empty is impossible, because done=0; cs_stall_mask on an empty lane SHALL be ignored.
REQ-029 Pointers SHALL wrap modulo DEPTH.
REQ-030 squash SHALL zero all counts and pointers at the next edge, overriding push and pop in the same cycle; stored data need not be cleared.
REQ-031 Lanes SHALL never interact; each lane's state depends only on its own signals and on squash.

Reset
REQ-032 On rst=1 all counts and pointers SHALL be 0 immediately (asynchronously): buf_done_flags=0, buf_count=0, fu_ready all 1.
REQ-033 Reset asserted mid-operation SHALL discard every buffered result; after reset is released, the first push is visible 1 cycle later.

Configuration
REQ-034 Macro FU_RESULT_BUFFER_FULL_STATS_EN: when defined, the module SHALL add output buf_full_cycles (NUM_FU*16).
- Each lane counts cycles with count==DEPTH & fu_valid=1.
- The counter saturates at 16'hFFFF.
- It is cleared by rst only, not by squash.
REQ-035 When FU_RESULT_BUFFER_FULL_STATS_EN is undefined, the port and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Reset, then lane 3 push {value=0x1234, prs=9, rob=4}, cs_stall_mask=0 -> next cycle buf_done_flags=0x08 and buf_value[3]=0x1234; one cycle later buf_done_flags=0x00.
REQ-037 Lane 0: push A, B with cs_stall_mask[0]=1 held -> count=2, fu_ready[0]=0; a third fu_valid is ignored; release the stall -> A, then B popped on successive cycles, count 2->1->0.
REQ-038 Lane 7 at count=1: push C and pop the head in the same cycle -> count stays 1 and the head becomes C with buf_br_taken[7]/buf_br_pc[7] from C.
REQ-039 All 8 lanes full (DEPTH=2), squash=1 with fu_valid=0xFF -> next cycle buf_count all 0, buf_done_flags=0x00, fu_ready=0xFF.
REQ-040 rst asserted mid-cycle with lanes 1 and 5 holding data -> buf_done_flags goes to 0 before the next clock edge.
REQ-041 With FU_RESULT_BUFFER_FULL_STATS_EN defined: lane 2 full with fu_valid[2]=1 for 10 cycles -> buf_full_cycles[2]=10; a squash leaves it at 10.

Source files
------------

// File: rtl/fu_result_buffer.sv
// fu_result_buffer: per-lane FU result FIFOs feeding the complete stage.
// Optional FU_RESULT_BUFFER_FULL_STATS_EN adds per-lane saturating full-while-valid counters.
module fu_result_buffer #(
    parameter int NUM_FU = 8,
    parameter int DEPTH  = 2,
    parameter int XLEN   = 32,
    parameter int PR_W   = 6,
    parameter int ROB_W  = 5
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   squash,
    input  logic [NUM_FU-1:0]                      fu_valid,
    input  logic [NUM_FU*XLEN-1:0]                 fu_value,
    input  logic [NUM_FU*PR_W-1:0]                 fu_prs,
    input  logic [NUM_FU*ROB_W-1:0]                fu_rob,
    input  logic [NUM_FU-1:0]                      fu_br_taken,
    input  logic [NUM_FU*XLEN-1:0]                 fu_br_pc,
    output logic [NUM_FU-1:0]                      fu_ready,
    input  logic [NUM_FU-1:0]                      cs_stall_mask,
    output logic [NUM_FU-1:0]                      buf_done_flags,
    output logic [NUM_FU*XLEN-1:0]                 buf_value,
    output logic [NUM_FU*PR_W-1:0]                 buf_prs,
    output logic [NUM_FU*ROB_W-1:0]                buf_rob,
    output logic [NUM_FU-1:0]                      buf_br_taken,
    output logic [NUM_FU*XLEN-1:0]                 buf_br_pc,
    output logic [NUM_FU*($clog2(DEPTH)+1)-1:0]    buf_count
`ifdef FU_RESULT_BUFFER_FULL_STATS_EN
    ,
    output logic [NUM_FU*16-1:0]                   buf_full_cycles
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EW    = 2*XLEN + PR_W + ROB_W + 1;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_lane
        logic [EW-1:0]    r_mem [DEPTH];
        logic [PTR_W-1:0] r_head, r_tail;
        logic [CNT_W-1:0] r_cnt;
        logic             w_push, w_pop;
        logic [EW-1:0]    w_in;

        assign w_in   = {fu_value[i*XLEN +: XLEN], fu_prs[i*PR_W +: PR_W], fu_rob[i*ROB_W +: ROB_W],
                         fu_br_taken[i], fu_br_pc[i*XLEN +: XLEN]};
        assign w_push = fu_valid[i] & fu_ready[i] & ~squash;
        assign w_pop  = buf_done_flags[i] & ~cs_stall_mask[i] & ~squash;

        assign fu_ready[i]       = r_cnt < CNT_W'(DEPTH);
        assign buf_done_flags[i] = r_cnt != '0;
        assign buf_count[i*CNT_W +: CNT_W] = r_cnt;
        assign {buf_value[i*XLEN +: XLEN], buf_prs[i*PR_W +: PR_W], buf_rob[i*ROB_W +: ROB_W],
                buf_br_taken[i], buf_br_pc[i*XLEN +: XLEN]} = r_mem[r_head];

        // Pointers are power-of-two wide, so natural overflow wraps modulo DEPTH.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_head <= '0;
                r_tail <= '0;
                r_cnt  <= '0;
            end else if (squash) begin
                r_head <= '0;
                r_tail <= '0;
                r_cnt  <= '0;
            end else begin
                r_head <= r_head + PTR_W'(w_pop);
                r_tail <= r_tail + PTR_W'(w_push);
                r_cnt  <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_tail] <= w_in;
        end

`ifdef FU_RESULT_BUFFER_FULL_STATS_EN
        logic [15:0] r_full;
        assign buf_full_cycles[i*16 +: 16] = r_full;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_full <= '0;
            else if (r_cnt == CNT_W'(DEPTH) && fu_valid[i] && r_full != 16'hFFFF) r_full <= r_full + 16'd1;
        end
`endif
    end
endmodule

// File: tb/tb_fu_result_buffer.sv
// tb_fu_result_buffer: directed vectors with hand-computed expectations for fu_result_buffer.
module tb_fu_result_buffer;
    logic         clk = 0;
    logic         rst, squash;
    logic [7:0]   fu_valid, fu_br_taken, fu_ready, cs_stall_mask, buf_done_flags, buf_br_taken;
    logic [255:0] fu_value, fu_br_pc, buf_value, buf_br_pc;
    logic [47:0]  fu_prs, buf_prs;
    logic [39:0]  fu_rob, buf_rob;
    logic [15:0]  buf_count;
`ifdef FU_RESULT_BUFFER_FULL_STATS_EN
    logic [127:0] buf_full_cycles;
`endif
    int n_chk = 0, n_pass = 0;

    fu_result_buffer dut (
        .clk(clk), .rst(rst), .squash(squash), .fu_valid(fu_valid), .fu_value(fu_value),
        .fu_prs(fu_prs), .fu_rob(fu_rob), .fu_br_taken(fu_br_taken), .fu_br_pc(fu_br_pc),
        .fu_ready(fu_ready), .cs_stall_mask(cs_stall_mask), .buf_done_flags(buf_done_flags),
        .buf_value(buf_value), .buf_prs(buf_prs), .buf_rob(buf_rob), .buf_br_taken(buf_br_taken),
        .buf_br_pc(buf_br_pc), .buf_count(buf_count)
`ifdef FU_RESULT_BUFFER_FULL_STATS_EN
        , .buf_full_cycles(buf_full_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int l, input logic [31:0] v, input logic [5:0] p, input logic [4:0] r,
                       input logic bt, input logic [31:0] pc);
        fu_valid[l]          = 1'b1;
        fu_value[l*32 +: 32] = v;
        fu_prs[l*6 +: 6]     = p;
        fu_rob[l*5 +: 5]     = r;
        fu_br_taken[l]       = bt;
        fu_br_pc[l*32 +: 32] = pc;
    endtask

    function automatic logic [31:0] val(input int l);
        return buf_value[l*32 +: 32];
    endfunction

    function automatic logic [1:0] cnt(input int l);
        return buf_count[l*2 +: 2];
    endfunction

    initial begin
        rst = 1; squash = 0; fu_valid = 0; fu_br_taken = 0; cs_stall_mask = 0;
        fu_value = '0; fu_br_pc = '0; fu_prs = '0; fu_rob = '0;
        #1;
        check("rst_done", buf_done_flags, 8'h00);
        check("rst_count", buf_count, 16'h0000);
        check("rst_ready", fu_ready, 8'hFF);
        tick();
        rst = 0;
        // single push on lane 3, no bypass, popped next cycle
        put(3, 32'h1234, 6'd9, 5'd4, 1'b0, 32'h0);
        #1;
        check("l3_no_bypass", buf_done_flags, 8'h00);
        tick();
        fu_valid = 0;
        check("l3_done", buf_done_flags, 8'h08);
        check("l3_value", val(3), 32'h1234);
        check("l3_prs", buf_prs[18 +: 6], 6'd9);
        check("l3_rob", buf_rob[15 +: 5], 5'd4);
        tick();
        check("l3_popped", buf_done_flags, 8'h00);
        // lane 0 fill under stall, overflow ignored, drain in order
        cs_stall_mask = 8'h01;
        put(0, 32'hAAAA, 6'd1, 5'd1, 1'b0, 32'h0);
        tick();
        put(0, 32'hBBBB, 6'd2, 5'd2, 1'b0, 32'h0);
        tick();
        check("l0_count_full", cnt(0), 2'd2);
        check("l0_ready_full", fu_ready[0], 1'b0);
        put(0, 32'hCCCC, 6'd3, 5'd3, 1'b0, 32'h0);
        tick();
        fu_valid = 0;
        check("l0_ovf_count", cnt(0), 2'd2);
        check("l0_head_A", val(0), 32'hAAAA);
        cs_stall_mask = 0;
        tick();
        check("l0_count_1", cnt(0), 2'd1);
        check("l0_head_B", val(0), 32'hBBBB);
        tick();
        check("l0_count_0", cnt(0), 2'd0);
        check("l0_empty", buf_done_flags[0], 1'b0);
        // lane 7 simultaneous push and pop
        cs_stall_mask = 8'h80;
        put(7, 32'hD0D0, 6'd5, 5'd5, 1'b0, 32'h100);
        tick();
        fu_valid = 0;
        check("l7_count_1", cnt(7), 2'd1);
        check("l7_pc_D", buf_br_pc[224 +: 32], 32'h100);
        cs_stall_mask = 0;
        put(7, 32'hC0C0, 6'd6, 5'd6, 1'b1, 32'h2000);
        tick();
        fu_valid = 0; fu_br_taken = 0;
        check("l7_pp_count", cnt(7), 2'd1);
        check("l7_pp_value", val(7), 32'hC0C0);
        check("l7_pp_taken", buf_br_taken[7], 1'b1);
        check("l7_pp_pc", buf_br_pc[224 +: 32], 32'h2000);
        tick();
        check("l7_drained", cnt(7), 2'd0);
        // fill all lanes, then squash with fu_valid held
        cs_stall_mask = 8'hFF;
        for (int l = 0; l < 8; l++) put(l, 32'h100 + l, 6'(l), 5'(l), 1'b0, 32'h0);
        tick();
        tick();
        check("all_full_count", buf_count, 16'hAAAA);
        check("all_full_ready", fu_ready, 8'h00);
        check("all_full_done", buf_done_flags, 8'hFF);
        squash = 1;
        tick();
        squash = 0; fu_valid = 0;
        check("sq_count", buf_count, 16'h0000);
        check("sq_done", buf_done_flags, 8'h00);
        check("sq_ready", fu_ready, 8'hFF);
        // pointer wrap on lane 0 via push+pop after squash
        cs_stall_mask = 0;
        put(0, 32'h11, 6'd0, 5'd0, 1'b0, 32'h0);
        tick();
        put(0, 32'h22, 6'd0, 5'd0, 1'b0, 32'h0);
        tick();
        check("wrap_head_2", val(0), 32'h22);
        put(0, 32'h33, 6'd0, 5'd0, 1'b0, 32'h0);
        tick();
        fu_valid = 0;
        check("wrap_head_3", val(0), 32'h33);
        check("wrap_count", cnt(0), 2'd1);
        tick();
        // async reset mid-cycle with lanes 1 and 5 holding data
        cs_stall_mask = 8'h22;
        put(1, 32'h5511, 6'd1, 5'd1, 1'b0, 32'h0);
        put(5, 32'h5555, 6'd5, 5'd5, 1'b0, 32'h0);
        tick();
        fu_valid = 0;
        check("pre_rst_done", buf_done_flags, 8'h22);
        #2 rst = 1;
        #1;
        check("async_rst_done", buf_done_flags, 8'h00);
        check("async_rst_count", buf_count, 16'h0000);
        check("async_rst_ready", fu_ready, 8'hFF);
        tick();
        rst = 0;
        cs_stall_mask = 0;
        put(1, 32'h7777, 6'd7, 5'd7, 1'b0, 32'h0);
        #1;
        check("post_rst_nobypass", buf_done_flags, 8'h00);
        tick();
        fu_valid = 0;
        check("post_rst_done", buf_done_flags, 8'h02);
        check("post_rst_value", val(1), 32'h7777);
        tick();
`ifdef FU_RESULT_BUFFER_FULL_STATS_EN
        cs_stall_mask = 8'h04;
        put(2, 32'h2222, 6'd2, 5'd2, 1'b0, 32'h0);
        tick();
        tick();
        for (int k = 0; k < 10; k++) tick();
        fu_valid = 0;
        check("stats_10", buf_full_cycles[32 +: 16], 16'd10);
        squash = 1;
        tick();
        squash = 0;
        check("stats_after_sq", buf_full_cycles[32 +: 16], 16'd10);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
